// File: rtl/nn_pkg.sv
// Shared neuron-layer defaults and output saturation bounds.
package nn_pkg;
   localparam int N_TERMS  = 4;
   localparam int DATA_W   = 8;
   localparam int WEIGHT_W = 8;
   localparam int ACC_W    = 20;
   localparam int OUT_W    = 8;
   localparam int SHIFT    = 4;
   localparam bit RELU     = 1'b1;

   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction
endpackage

// File: rtl/acc_sat_relu.sv
// Combinational fraction drop, signed saturation to OUT_W and optional ReLU.
module acc_sat_relu #(
   parameter int ACC_W = nn_pkg::ACC_W,
   parameter int OUT_W = nn_pkg::OUT_W,
   parameter int SHIFT = nn_pkg::SHIFT,
   parameter bit RELU  = nn_pkg::RELU
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [OUT_W-1:0] y,
   output logic                    overflow
);
   localparam logic signed [ACC_W-1:0] HI = ACC_W'(nn_pkg::sat_max(OUT_W));
   localparam logic signed [ACC_W-1:0] LO = ACC_W'(nn_pkg::sat_min(OUT_W));

   logic signed [ACC_W-1:0] s;

   always_comb begin
      s        = acc >>> SHIFT;
      y        = s[OUT_W-1:0];
      overflow = 1'b0;
      if (s > HI) begin
         y        = HI[OUT_W-1:0];
         overflow = 1'b1;
      end else if (s < LO) begin
         y        = LO[OUT_W-1:0];
         overflow = 1'b1;
      end
      // overflow deliberately reports the pre-ReLU saturation
      if (RELU && y[OUT_W-1]) y = '0;
   end
endmodule

// File: rtl/neuron_acc_datapath.sv
// Neuron MAC datapath: product stage, windowed accumulator, scaled result on a
// single-entry valid/ready output, plus drop and sequencing error pulses.
module neuron_acc_datapath #(
   parameter int N_TERMS  = nn_pkg::N_TERMS,
   parameter int DATA_W   = nn_pkg::DATA_W,
   parameter int WEIGHT_W = nn_pkg::WEIGHT_W,
   parameter int ACC_W    = nn_pkg::ACC_W,
   parameter int OUT_W    = nn_pkg::OUT_W,
   parameter int SHIFT    = nn_pkg::SHIFT,
   parameter bit RELU     = nn_pkg::RELU
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sel,
   input  logic                       en,
   input  logic signed [DATA_W-1:0]   x_in,
   input  logic signed [WEIGHT_W-1:0] w_in,
   input  logic signed [ACC_W-1:0]    bias,
   output logic signed [OUT_W-1:0]    y_data,
   output logic                       y_valid,
   input  logic                       y_ready,
   output logic                       overflow,
   output logic                       drop_err,
   output logic                       seq_err
);
   localparam int PW = DATA_W + WEIGHT_W;
   localparam int CW = $clog2(N_TERMS + 1) + 1;

   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] p, bias_d, acc, acc_n;
   logic                    sel_d, en_d;
   logic [CW-1:0]           cnt, cnt_next;
   logic signed [OUT_W-1:0] y_n;
   logic                    ovf_n;

   assign prod = x_in * w_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         p      <= '0;
         bias_d <= '0;
         sel_d  <= 1'b0;
         en_d   <= 1'b0;
      end else begin
         p      <= {{(ACC_W-PW){prod[PW-1]}}, prod};
         bias_d <= bias;
         sel_d  <= sel;
         en_d   <= en;
      end
   end

   // cnt == 0 means no window is open; it only advances inside a window
   always_comb begin
      acc_n = sel_d ? bias_d + p : acc + p;
      if (sel_d)         cnt_next = CW'(1);
      else if (cnt == 0) cnt_next = '0;
      else if (&cnt)     cnt_next = cnt;
      else               cnt_next = cnt + CW'(1);
   end

   acc_sat_relu #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(RELU)) u_sat (
      .acc      (acc_n),
      .y        (y_n),
      .overflow (ovf_n)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         cnt      <= '0;
         y_data   <= '0;
         y_valid  <= 1'b0;
         overflow <= 1'b0;
         drop_err <= 1'b0;
         seq_err  <= 1'b0;
      end else begin
         acc      <= acc_n;
         cnt      <= en_d ? '0 : cnt_next;
         seq_err  <= (en_d && (cnt_next != CW'(N_TERMS))) || (sel_d && (cnt != 0));
         drop_err <= en_d && y_valid && !y_ready;
         if (en_d && (!y_valid || y_ready)) begin
            y_data   <= y_n;
            overflow <= ovf_n;
            y_valid  <= 1'b1;
         end else if (y_valid && y_ready) begin
            y_valid  <= 1'b0;
         end
      end
   end
endmodule
